// File: rtl/neighbor_table_update_pkg.sv
// Shared memory map, sizes and FSM encoding for the node's neighbor table.
// Both the table reader (selectMyAction) and writer (neighbor_table_update)
// import this package so the two agree on every address.
package wsn_mem_map;

  localparam int WORD_WIDTH    = 16;
  localparam int ADDR_WIDTH    = 11;
  localparam int MAX_NEIGHBORS = 64;

  // Region base addresses (byte addresses, 2 bytes per entry).
  localparam logic [ADDR_WIDTH-1:0] NEIGHBOR_ID_BASE    = 11'h048;
  localparam logic [ADDR_WIDTH-1:0] CLUSTER_ID_BASE     = 11'h0C8;
  localparam logic [ADDR_WIDTH-1:0] BATTERY_STAT_BASE   = 11'h148;
  localparam logic [ADDR_WIDTH-1:0] Q_VALUE_BASE        = 11'h1C8;
  localparam logic [ADDR_WIDTH-1:0] NEIGHBOR_COUNT_ADDR = 11'h68A;

  // Region select understood by the address generator.
  typedef enum logic [2:0] {
    RGN_NONE,
    RGN_ID,
    RGN_CLUSTER,
    RGN_BATTERY,
    RGN_QVALUE,
    RGN_COUNT
  } region_e;

  // Table-update FSM encoding.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_CNT,
    ST_LD_CNT,
    ST_SCAN_RD,
    ST_SCAN_CMP,
    ST_WR_ID,
    ST_WR_CID,
    ST_WR_BAT,
    ST_WR_Q,
    ST_WR_CNT,
    ST_DONE
  } nt_state_e;

endpackage

// File: rtl/neighbor_table_update_if.sv
// Single-port shared-memory bus. The table logic is the master; the memory
// (or the arbiter in front of it) is the slave. Read data returns one cycle
// after the address is presented.
interface neighbor_table_update_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 16
) ();

  logic [ADDR_WIDTH-1:0] address;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic [DATA_WIDTH-1:0] mem_data_in;

  modport master (
    output address,
    output wr_en,
    output data_out,
    input  mem_data_in
  );

  modport slave (
    input  address,
    input  wr_en,
    input  data_out,
    output mem_data_in
  );

endinterface

// File: rtl/neighbor_table_update_addr_gen.sv
// Combinational address generator: maps a table region and entry index to
// the 11-bit byte address. The count word has no index.
module nt_addr_gen
  import wsn_mem_map::*;
#(
  parameter int IDX_WIDTH = 6
) (
  input  region_e                region_i,
  input  logic [IDX_WIDTH-1:0]   index_i,
  output logic [ADDR_WIDTH-1:0]  addr_o
);

  logic [ADDR_WIDTH-1:0] offset;

  // Entries are one word (two bytes) apart.
  assign offset = ADDR_WIDTH'({index_i, 1'b0});

  // Select the region base and add the entry offset; idle regions read as 0.
  always_comb begin
    addr_o = '0;
    case (region_i)
      RGN_ID:      addr_o = NEIGHBOR_ID_BASE + offset;
      RGN_CLUSTER: addr_o = CLUSTER_ID_BASE + offset;
      RGN_BATTERY: addr_o = BATTERY_STAT_BASE + offset;
      RGN_QVALUE:  addr_o = Q_VALUE_BASE + offset;
      RGN_COUNT:   addr_o = NEIGHBOR_COUNT_ADDR;
      default:     addr_o = '0;
    endcase
  end

endmodule

// File: rtl/neighbor_table_update.sv
// Neighbor table writer. On a received beacon it scans the neighborID list
// for the sender; a hit rewrites that entry's cluster/battery/Q fields, a
// miss appends a new entry and bumps neighborCount. The count is written
// last so a reader never sees a half-built entry.
module neighbor_table_update #(
  parameter int MAX_NEIGHBORS = wsn_mem_map::MAX_NEIGHBORS,
  parameter int WORD_WIDTH    = wsn_mem_map::WORD_WIDTH
) (
  input  logic                  clock,
  input  logic                  nrst,
  input  logic                  en,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] pkt_id,
  input  logic [WORD_WIDTH-1:0] pkt_cluster,
  input  logic [WORD_WIDTH-1:0] pkt_battery,
  input  logic [WORD_WIDTH-1:0] pkt_qvalue,
  neighbor_table_update_if.master mem,
  output logic                  done,
  output logic                  table_full,
  output logic                  is_new
);

  import wsn_mem_map::*;

  localparam int IDX_W = $clog2(MAX_NEIGHBORS);
  localparam int CNT_W = IDX_W + 1;

  nt_state_e             state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0] id_q, id_d;
  logic [WORD_WIDTH-1:0] cid_q, cid_d;
  logic [WORD_WIDTH-1:0] bat_q, bat_d;
  logic [WORD_WIDTH-1:0] qv_q, qv_d;
  logic                  append_q, append_d;
  logic                  table_full_q, table_full_d;
  logic                  is_new_q, is_new_d;

  region_e               region_c;
  logic                  wr_en_c;
  logic [WORD_WIDTH-1:0] wdata_c;
  logic [ADDR_WIDTH-1:0] addr_c;
  logic [CNT_W-1:0]      idx_plus1_c;

  assign idx_plus1_c = {1'b0, idx_q} + CNT_W'(1);

  nt_addr_gen #(
    .IDX_WIDTH (IDX_W)
  ) u_addr_gen (
    .region_i (region_c),
    .index_i  (idx_q),
    .addr_o   (addr_c)
  );

  // State and datapath registers, cleared by the synchronous reset.
  always_ff @(posedge clock) begin
    if (nrst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      id_q         <= '0;
      cid_q        <= '0;
      bat_q        <= '0;
      qv_q         <= '0;
      append_q     <= 1'b0;
      table_full_q <= 1'b0;
      is_new_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      id_q         <= id_d;
      cid_q        <= cid_d;
      bat_q        <= bat_d;
      qv_q         <= qv_d;
      append_q     <= append_d;
      table_full_q <= table_full_d;
      is_new_q     <= is_new_d;
    end
  end

  // Next-state and bus outputs; outputs depend only on registered state.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    id_d         = id_q;
    cid_d        = cid_q;
    bat_d        = bat_q;
    qv_d         = qv_q;
    append_d     = append_q;
    table_full_d = table_full_q;
    is_new_d     = is_new_q;
    region_c     = RGN_NONE;
    wr_en_c      = 1'b0;
    wdata_c      = '0;

    case (state_q)
      ST_IDLE: begin
        // done is low by construction while idle, so start alone arms us.
        if (start) begin
          id_d     = pkt_id;
          cid_d    = pkt_cluster;
          bat_d    = pkt_battery;
          qv_d     = pkt_qvalue;
          append_d = 1'b0;
          state_d  = ST_RD_CNT;
        end
      end

      ST_RD_CNT: begin
        region_c = RGN_COUNT;
        state_d  = ST_LD_CNT;
      end

      ST_LD_CNT: begin
        // A corrupt count larger than the table is clamped to capacity.
        if (mem.mem_data_in >= WORD_WIDTH'(MAX_NEIGHBORS)) begin
          cnt_d = CNT_W'(MAX_NEIGHBORS);
        end else begin
          cnt_d = mem.mem_data_in[CNT_W-1:0];
        end
        idx_d = '0;
        if (cnt_d == '0) begin
          append_d = 1'b1;
          state_d  = ST_WR_ID;
        end else begin
          state_d  = ST_SCAN_RD;
        end
      end

      ST_SCAN_RD: begin
        region_c = RGN_ID;
        state_d  = ST_SCAN_CMP;
      end

      ST_SCAN_CMP: begin
        if (mem.mem_data_in == id_q) begin
          state_d = ST_WR_CID;
        end else if (idx_plus1_c < cnt_q) begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_SCAN_RD;
        end else if (cnt_q < CNT_W'(MAX_NEIGHBORS)) begin
          idx_d    = cnt_q[IDX_W-1:0];
          append_d = 1'b1;
          state_d  = ST_WR_ID;
        end else begin
          table_full_d = 1'b1;
          state_d      = ST_DONE;
        end
      end

      ST_WR_ID: begin
        region_c = RGN_ID;
        wr_en_c  = 1'b1;
        wdata_c  = id_q;
        state_d  = ST_WR_CID;
      end

      ST_WR_CID: begin
        region_c = RGN_CLUSTER;
        wr_en_c  = 1'b1;
        wdata_c  = cid_q;
        state_d  = ST_WR_BAT;
      end

      ST_WR_BAT: begin
        region_c = RGN_BATTERY;
        wr_en_c  = 1'b1;
        wdata_c  = bat_q;
        state_d  = ST_WR_Q;
      end

      ST_WR_Q: begin
        region_c = RGN_QVALUE;
        wr_en_c  = 1'b1;
        wdata_c  = qv_q;
        state_d  = append_q ? ST_WR_CNT : ST_DONE;
      end

      ST_WR_CNT: begin
        // Publishing the new count is what makes the appended entry visible.
        region_c = RGN_COUNT;
        wr_en_c  = 1'b1;
        wdata_c  = WORD_WIDTH'(cnt_q) + WORD_WIDTH'(1);
        is_new_d = 1'b1;
        state_d  = ST_DONE;
      end

      ST_DONE: begin
        state_d = ST_DONE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // en re-arms the block: clears status and abandons any operation.
    if (en) begin
      table_full_d = 1'b0;
      is_new_d     = 1'b0;
      if (state_q != ST_IDLE) begin
        state_d = ST_IDLE;
      end
    end
  end

  assign mem.address  = addr_c;
  assign mem.wr_en    = wr_en_c;
  assign mem.data_out = wdata_c;
  assign done         = (state_q == ST_DONE);
  assign table_full   = table_full_q;
  assign is_new       = is_new_q;

endmodule

// File: tb/tb_neighbor_table_update.sv
// Directed bench for the neighbor table writer: a behavioural memory, a
// queue of expected writes filled when each packet is launched and drained
// by a write monitor, and immediate-assertion checks on status outputs.
module tb_neighbor_table_update;

  localparam logic [9:0] CNT_WORD = 10'h345;

  typedef struct packed {
    logic [10:0] addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  logic        clk = 1'b0;
  logic        nrst = 1'b1;
  logic        en = 1'b0;
  logic        start = 1'b0;
  logic [15:0] pkt_id = '0;
  logic [15:0] pkt_cluster = '0;
  logic [15:0] pkt_battery = '0;
  logic [15:0] pkt_qvalue = '0;
  logic        done;
  logic        table_full;
  logic        is_new;

  logic        tb_wr = 1'b0;
  logic [10:0] tb_addr = '0;
  logic [15:0] tb_data = '0;
  logic [15:0] mem_words [0:1023];

  int  cyc = 0;
  int  base_cyc = 0;
  int  compared = 0;
  int  mismatched = 0;
  wr_t exp_q [$];

  neighbor_table_update_if #(.ADDR_WIDTH(11), .DATA_WIDTH(16)) mem_bus ();

  neighbor_table_update dut (
    .clock       (clk),
    .nrst        (nrst),
    .en          (en),
    .start       (start),
    .pkt_id      (pkt_id),
    .pkt_cluster (pkt_cluster),
    .pkt_battery (pkt_battery),
    .pkt_qvalue  (pkt_qvalue),
    .mem         (mem_bus),
    .done        (done),
    .table_full  (table_full),
    .is_new      (is_new)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port memory with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_bus.wr_en === 1'b1) mem_words[mem_bus.address[10:1]] <= mem_bus.data_out;
    else if (tb_wr) mem_words[tb_addr[10:1]] <= tb_data;
    mem_bus.mem_data_in <= mem_words[mem_bus.address[10:1]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every write strobe must match the next expected write, cycle included.
  always @(negedge clk) begin
    if (mem_bus.wr_en === 1'b1) begin
      wr_t e;
      $display("write addr=%h data=%h cycle=%0d", mem_bus.address, mem_bus.data_out, cyc - base_cyc);
      compared++;
      assert (exp_q.size() != 0) else begin
        mismatched++;
        $error("FAIL unexpected_write: observed addr %h data %h expected no write",
               mem_bus.address, mem_bus.data_out);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("write_addr_data", {5'd0, mem_bus.address, mem_bus.data_out}, {5'd0, e.addr, e.data});
        chk("write_cycle", cyc - base_cyc, e.cyc);
      end
    end
  end

  task automatic expect_wr(input logic [10:0] a, input logic [15:0] d, input int c);
    wr_t e;
    e.addr = a; e.data = d; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic poke(input logic [10:0] a, input logic [15:0] d);
    tb_addr = a; tb_data = d; tb_wr = 1'b1;
    @(negedge clk);
    tb_wr = 1'b0;
  endtask

  // Called at a negedge with the DUT idle; that cycle is cycle 0.
  task automatic launch(input logic [15:0] id, input logic [15:0] cl,
                        input logic [15:0] bt, input logic [15:0] qv, input bit hold);
    pkt_id = id; pkt_cluster = cl; pkt_battery = bt; pkt_qvalue = qv;
    start = 1'b1;
    base_cyc = cyc;
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_rel);
    int n = 0;
    while (done !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_cycle"}, (done === 1'b1) ? (cyc - base_cyc) : -1, exp_rel);
    chk({tag, "_pending_writes"}, exp_q.size(), 0);
    $display("op %s finished at cycle %0d is_new=%b table_full=%b", tag, cyc - base_cyc, is_new, table_full);
  endtask

  // Leaves the DUT idle; the returned-to cycle is a valid cycle 0.
  task automatic pulse_en(input string tag);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    base_cyc = cyc;
    chk({tag, "_done_cleared"}, done, 0);
    chk({tag, "_is_new_cleared"}, is_new, 0);
    chk({tag, "_full_cleared"}, table_full, 0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_done", done, 0);
    chk("rst_full", table_full, 0);
    chk("rst_is_new", is_new, 0);
    chk("rst_wr_en", mem_bus.wr_en, 0);
    chk("rst_address", mem_bus.address, 0);
    chk("rst_data_out", mem_bus.data_out, 0);
    nrst = 1'b0;
    @(negedge clk);

    // 1: empty table, append at index 0
    poke(11'h68A, 16'd0);
    expect_wr(11'h048, 16'd51, 3);
    expect_wr(11'h0C8, 16'h0007, 4);
    expect_wr(11'h148, 16'h0030, 5);
    expect_wr(11'h1C8, 16'h1234, 6);
    expect_wr(11'h68A, 16'd1, 7);
    launch(16'd51, 16'h0007, 16'h0030, 16'h1234, 1'b0);
    wait_done("t1", 8);
    chk("t1_is_new", is_new, 1);
    chk("t1_full", table_full, 0);
    chk("t1_count", mem_words[CNT_WORD], 1);
    pulse_en("t1");

    // 2: hit at index 1, fields updated in place
    poke(11'h048, 16'd12);
    poke(11'h04A, 16'd51);
    poke(11'h04C, 16'd65);
    poke(11'h68A, 16'd3);
    expect_wr(11'h0CA, 16'h0009, 7);
    expect_wr(11'h14A, 16'h0020, 8);
    expect_wr(11'h1CA, 16'h0055, 9);
    launch(16'd51, 16'h0009, 16'h0020, 16'h0055, 1'b0);
    wait_done("t2", 10);
    chk("t2_is_new", is_new, 0);
    chk("t2_battery", mem_words[10'h0A5], 16'h0020);
    chk("t2_count", mem_words[CNT_WORD], 3);
    pulse_en("t2");

    // 3: miss with count 3, append at index 3
    expect_wr(11'h04E, 16'd99, 9);
    expect_wr(11'h0CE, 16'd3, 10);
    expect_wr(11'h14E, 16'd4, 11);
    expect_wr(11'h1CE, 16'd5, 12);
    expect_wr(11'h68A, 16'd4, 13);
    launch(16'd99, 16'd3, 16'd4, 16'd5, 1'b0);
    wait_done("t3", 14);
    chk("t3_is_new", is_new, 1);
    chk("t3_count", mem_words[CNT_WORD], 4);
    pulse_en("t3");

    // 4: full table, unknown sender, no writes at all
    for (int i = 0; i < 64; i++) poke(11'h048 + 11'(2 * i), 16'(1000 + i));
    poke(11'h68A, 16'd64);
    launch(16'd7777, 16'd1, 16'd2, 16'd3, 1'b0);
    wait_done("t4", 131);
    chk("t4_full", table_full, 1);
    chk("t4_is_new", is_new, 0);
    chk("t4_count", mem_words[CNT_WORD], 64);
    pulse_en("t4");

    // 5: reset during WR_BAT of an append, then rerun
    poke(11'h68A, 16'd3);
    expect_wr(11'h04E, 16'd200, 9);
    expect_wr(11'h0CE, 16'h00A1, 10);
    expect_wr(11'h14E, 16'h00A2, 11);
    launch(16'd200, 16'h00A1, 16'h00A2, 16'h00A3, 1'b0);
    repeat (10) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    chk("t5_rst_wr_en", mem_bus.wr_en, 0);
    chk("t5_rst_done", done, 0);
    chk("t5_rst_pending", exp_q.size(), 0);
    nrst = 1'b0;
    @(negedge clk);
    chk("t5_count_kept", mem_words[CNT_WORD], 3);
    $display("op t5 aborted by reset, count=%0d", mem_words[CNT_WORD]);
    expect_wr(11'h04E, 16'd200, 9);
    expect_wr(11'h0CE, 16'h00A1, 10);
    expect_wr(11'h14E, 16'h00A2, 11);
    expect_wr(11'h1CE, 16'h00A3, 12);
    expect_wr(11'h68A, 16'd4, 13);
    launch(16'd200, 16'h00A1, 16'h00A2, 16'h00A3, 1'b0);
    wait_done("t5", 14);
    chk("t5_is_new", is_new, 1);
    chk("t5_count", mem_words[CNT_WORD], 4);
    pulse_en("t5");

    // 6: start held across done; one append, then one in-place update
    expect_wr(11'h050, 16'd300, 11);
    expect_wr(11'h0D0, 16'h0011, 12);
    expect_wr(11'h150, 16'h0022, 13);
    expect_wr(11'h1D0, 16'h0033, 14);
    expect_wr(11'h68A, 16'd5, 15);
    launch(16'd300, 16'h0011, 16'h0022, 16'h0033, 1'b1);
    wait_done("t6a", 16);
    chk("t6a_is_new", is_new, 1);
    repeat (20) @(negedge clk);
    chk("t6_done_held", done, 1);
    chk("t6_no_extra_writes", exp_q.size(), 0);
    pkt_cluster = 16'h0066; pkt_battery = 16'h0077; pkt_qvalue = 16'h0088;
    expect_wr(11'h0D0, 16'h0066, 13);
    expect_wr(11'h150, 16'h0077, 14);
    expect_wr(11'h1D0, 16'h0088, 15);
    pulse_en("t6a");
    wait_done("t6b", 16);
    start = 1'b0;
    chk("t6b_is_new", is_new, 0);
    chk("t6b_count", mem_words[CNT_WORD], 5);
    chk("t6b_battery", mem_words[10'h0A8], 16'h0077);
    pulse_en("t6b");

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
